// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the writeback path.
//   DATA_W / ADDR_W : register data width and register index width
//   REG_ZERO        : hard-wired zero register, never written
//   LINK_REG        : destination of JAL link writes
//   LINK_OFFSET     : added to the JAL PC to form the link value
//   req_e           : writeback requester index, also the round-robin order
package cpu_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned REG_ZERO    = 0;
    localparam int unsigned LINK_REG    = 31;
    localparam int unsigned LINK_OFFSET = 4;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_MEM = 2'd1,
        REQ_LNK = 2'd2
    } req_e;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid[2:0] : request vector, bit order {LNK, MEM, ALU}
//   grant[2:0] : one-hot grant, forced low while rst_n is low
// The pointer names the requester with highest priority this cycle. After a
// grant it moves to the requester following the winner; with no requests it
// holds.
module rr_arbiter3
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] valid,
    output logic [2:0] grant
);

    req_e       ptr_q, ptr_d;
    logic [2:0] pick;

    always_comb begin
        pick = 3'b000;
        case (ptr_q)
            REQ_MEM: begin
                if (valid[1])      pick = 3'b010;
                else if (valid[2]) pick = 3'b100;
                else if (valid[0]) pick = 3'b001;
            end
            REQ_LNK: begin
                if (valid[2])      pick = 3'b100;
                else if (valid[0]) pick = 3'b001;
                else if (valid[1]) pick = 3'b010;
            end
            default: begin
                if (valid[0])      pick = 3'b001;
                else if (valid[1]) pick = 3'b010;
                else if (valid[2]) pick = 3'b100;
            end
        endcase
    end

    // Gating with rst_n keeps every ready low during reset.
    assign grant = pick & {3{rst_n}};

    always_comb begin
        ptr_d = ptr_q;
        case (grant)
            3'b001:  ptr_d = REQ_MEM;
            3'b010:  ptr_d = REQ_LNK;
            3'b100:  ptr_d = REQ_ALU;
            default: ptr_d = ptr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port owner shared by ALU, load-return and JAL-link
// writeback, plus a pending-write scoreboard for decode hazard detection.
//   CLK, RST_n                : clock, asynchronous active-low reset
//   alu_* / mem_* / lnk_*     : valid/ready writeback handshakes
//   issue_en, issue_addr      : decode reserves a destination register
//   issue_block               : issue_addr already pending (combinational)
//   RegisterS/T, HazardS/T    : source indices and their pending status
//   wr_en, wr_addr, wr_data   : registered register-file write port
//   err_waw                   : sticky, issue to an already-pending register
//   idle                      : nothing pending, requested or being written
module regfile_write_arbiter #(
    parameter int unsigned DATA_W      = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W      = cpu_pkg::ADDR_W,
    parameter int unsigned LINK_REG    = cpu_pkg::LINK_REG,
    parameter int unsigned LINK_OFFSET = cpu_pkg::LINK_OFFSET
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              lnk_valid,
    output logic              lnk_ready,
    input  logic [DATA_W-1:0] lnk_pc,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_block,
    input  logic [ADDR_W-1:0] RegisterS,
    input  logic [ADDR_W-1:0] RegisterT,
    output logic              HazardS,
    output logic              HazardT,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              err_waw,
    output logic              idle
);
    import cpu_pkg::*;

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [2:0]        valid;
    logic [2:0]        grant;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              wr_en_d;
    logic [NREG-1:0]   sb_q, sb_d;
    logic              err_waw_d;

    assign valid = {lnk_valid, mem_valid, alu_valid};

    rr_arbiter3 u_arb (
        .clk   (CLK),
        .rst_n (RST_n),
        .valid (valid),
        .grant (grant)
    );

    // A grant is only ever given to a valid requester, so grant == transfer.
    assign alu_ready = grant[0];
    assign mem_ready = grant[1];
    assign lnk_ready = grant[2];
    assign xfer      = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (grant)
            3'b001: begin
                sel_addr = alu_addr;
                sel_data = alu_data;
            end
            3'b010: begin
                sel_addr = mem_addr;
                sel_data = mem_data;
            end
            3'b100: begin
                sel_addr = ADDR_W'(LINK_REG);
                sel_data = lnk_pc + DATA_W'(LINK_OFFSET);
            end
            default: begin
                sel_addr = '0;
                sel_data = '0;
            end
        endcase
    end

    // Writes to the zero register are accepted but never reach the port.
    assign wr_en_d = xfer & (sel_addr != ADDR_W'(REG_ZERO));

    // Clear on acceptance, then set, so a same-edge reserve wins.
    always_comb begin
        sb_d = sb_q;
        if (xfer) begin
            sb_d[sel_addr] = 1'b0;
        end
        if (issue_en) begin
            sb_d[issue_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    assign issue_block = sb_q[issue_addr] & (issue_addr != ADDR_W'(REG_ZERO));
    assign err_waw_d   = err_waw | (issue_en & issue_block);

    // Bit 0 of the scoreboard is never set, so register 0 never hazards.
    assign HazardS = sb_q[RegisterS];
    assign HazardT = sb_q[RegisterT];

    assign idle = (sb_q == '0) & ~(|valid) & ~wr_en;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            sb_q    <= '0;
            err_waw <= 1'b0;
        end else begin
            wr_en   <= wr_en_d;
            sb_q    <= sb_d;
            err_waw <= err_waw_d;
            if (wr_en_d) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        CLK;
    logic        RST_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        lnk_valid, lnk_ready;
    logic [31:0] lnk_pc;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        issue_block;
    logic [4:0]  RegisterS, RegisterT;
    logic        HazardS, HazardT;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        err_waw;
    logic        idle;

    int errors = 0;
    int checks = 0;

    // Expected grant vectors {lnk,mem,alu} and expected writes {addr,data}.
    logic [2:0]  exp_grant[$];
    logic [36:0] exp_wr[$];

    logic [2:0]  mon_g;
    logic [2:0]  mon_eg;
    logic [36:0] mon_ew;

    regfile_write_arbiter dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .lnk_valid   (lnk_valid),
        .lnk_ready   (lnk_ready),
        .lnk_pc      (lnk_pc),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .issue_block (issue_block),
        .RegisterS   (RegisterS),
        .RegisterT   (RegisterT),
        .HazardS     (HazardS),
        .HazardT     (HazardT),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .err_waw     (err_waw),
        .idle        (idle)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares grants and writes against the scoreboard queues.
    always @(negedge CLK) begin
        mon_g = {lnk_ready, mem_ready, alu_ready};
        if (mon_g != 3'b000) begin
            if (exp_grant.size() == 0) begin
                check("unexpected_grant", {29'd0, mon_g}, 32'd0);
            end else begin
                mon_eg = exp_grant.pop_front();
                check("grant", {29'd0, mon_g}, {29'd0, mon_eg});
            end
        end
        if (wr_en) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write_addr", {27'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_ew = exp_wr.pop_front();
                check("wr_addr", {27'd0, wr_addr}, {27'd0, mon_ew[36:32]});
                check("wr_data", wr_data, mon_ew[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST_n = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
        mem_valid = 1'b0; mem_addr = '0;   mem_data = '0;
        lnk_valid = 1'b0; lnk_pc = '0;
        issue_en = 1'b0;  issue_addr = '0;
        RegisterS = 5'd5; RegisterT = 5'd0;

        // Reset with a request pending
        tick(); tick();
        @(negedge CLK);
        check("rst_wr_en", wr_en, 0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_hazard_s", HazardS, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_err_waw", err_waw, 0);
        exp_grant.push_back(3'b001); exp_wr.push_back({5'd5, 32'h11});
        tick(); RST_n = 1'b1;
        @(negedge CLK);
        check("post_rst_alu_ready", alu_ready, 1);
        tick(); alu_valid = 1'b0;
        @(negedge CLK);
        check("latency1_wr_en", wr_en, 1);

        // Link write with PC wrap (pointer at MEM, LNK is the lone requester)
        tick(); lnk_valid = 1'b1; lnk_pc = 32'hFFFF_FFFC;
        exp_grant.push_back(3'b100); exp_wr.push_back({5'd31, 32'h0});
        tick(); lnk_valid = 1'b0;
        @(negedge CLK);
        check("wrap_wr_data", wr_data, 32'h0);

        // Contention: pointer now at ALU
        tick();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hA;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'hB;
        lnk_valid = 1'b1; lnk_pc = 32'h100;
        exp_grant.push_back(3'b001); exp_wr.push_back({5'd3, 32'hA});
        exp_grant.push_back(3'b010); exp_wr.push_back({5'd4, 32'hB});
        exp_grant.push_back(3'b100); exp_wr.push_back({5'd31, 32'h104});
        tick(); alu_valid = 1'b0;
        tick(); mem_valid = 1'b0;
        tick(); lnk_valid = 1'b0;

        // Fairness: ALU and MEM both held valid for six cycles
        tick();
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h20;
        mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 32'h30;
        for (int i = 0; i < 3; i++) begin
            exp_grant.push_back(3'b001); exp_wr.push_back({5'd10, 32'h20});
            exp_grant.push_back(3'b010); exp_wr.push_back({5'd11, 32'h30});
        end
        repeat (6) tick();
        alu_valid = 1'b0; mem_valid = 1'b0;

        // Scoreboard: reserve 7, clear via load return (pointer at LNK)
        tick(); issue_en = 1'b1; issue_addr = 5'd7; RegisterS = 5'd7; RegisterT = 5'd7;
        @(negedge CLK);
        check("issue7_block", issue_block, 0);
        tick(); issue_en = 1'b0;
        @(negedge CLK);
        check("hazard_s_7", HazardS, 1);
        check("hazard_t_7", HazardT, 1);
        tick(); mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
        exp_grant.push_back(3'b010); exp_wr.push_back({5'd7, 32'h77});
        @(negedge CLK);
        check("hazard_s_accept_cycle", HazardS, 1);
        tick(); mem_valid = 1'b0;
        @(negedge CLK);
        check("hazard_s_inflight", HazardS, 0);
        check("inflight_wr_en", wr_en, 1);

        // Same-edge reserve and write of 7: reserve wins
        tick(); issue_en = 1'b1; issue_addr = 5'd7; mem_valid = 1'b1; mem_data = 32'h78;
        exp_grant.push_back(3'b010); exp_wr.push_back({5'd7, 32'h78});
        tick(); issue_en = 1'b0; mem_valid = 1'b0;
        @(negedge CLK);
        check("same_edge_hazard_s", HazardS, 1);
        tick(); mem_valid = 1'b1; mem_data = 32'h79;
        exp_grant.push_back(3'b010); exp_wr.push_back({5'd7, 32'h79});
        tick(); mem_valid = 1'b0;
        @(negedge CLK);
        check("cleared_hazard_s", HazardS, 0);

        // Register zero (pointer at LNK -> ALU wins)
        tick(); alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFF;
        exp_grant.push_back(3'b001);
        @(negedge CLK);
        check("r0_alu_ready", alu_ready, 1);
        tick(); alu_valid = 1'b0;
        @(negedge CLK);
        check("r0_wr_en", wr_en, 0);
        check("r0_wr_addr_hold", wr_addr, 7);
        check("r0_wr_data_hold", wr_data, 32'h79);
        tick(); issue_en = 1'b1; issue_addr = 5'd0; RegisterS = 5'd0;
        @(negedge CLK);
        check("r0_issue_block", issue_block, 0);
        tick(); issue_en = 1'b0;
        @(negedge CLK);
        check("r0_hazard_s", HazardS, 0);

        // WAW on 9 (pointer at MEM)
        tick(); issue_en = 1'b1; issue_addr = 5'd9; RegisterS = 5'd9;
        @(negedge CLK);
        check("waw_first_block", issue_block, 0);
        tick();
        @(negedge CLK);
        check("waw_second_block", issue_block, 1);
        check("waw_err_before", err_waw, 0);
        tick(); issue_en = 1'b0;
        @(negedge CLK);
        check("waw_err_set", err_waw, 1);
        check("waw_bit_kept", HazardS, 1);
        tick();
        @(negedge CLK);
        check("waw_err_sticky", err_waw, 1);
        tick(); alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        exp_grant.push_back(3'b001); exp_wr.push_back({5'd9, 32'h99});
        tick(); alu_valid = 1'b0;
        @(negedge CLK);
        check("waw_hazard_cleared", HazardS, 0);
        check("waw_err_after_write", err_waw, 1);
        check("busy_not_idle", idle, 0);
        tick();
        @(negedge CLK);
        check("idle", idle, 1);

        // Reset mid-transfer discards the in-flight write (pointer at MEM)
        tick(); alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h66;
        issue_en = 1'b1; issue_addr = 5'd12; RegisterS = 5'd12;
        exp_grant.push_back(3'b001);
        tick(); issue_en = 1'b0; RST_n = 1'b0;
        @(negedge CLK);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_alu_ready", alu_ready, 0);
        check("midrst_hazard_s", HazardS, 0);
        check("midrst_err_waw", err_waw, 0);
        check("midrst_wr_addr", wr_addr, 0);
        tick(); RST_n = 1'b1; alu_valid = 1'b0;
        @(negedge CLK);
        check("post_midrst_idle", idle, 1);

        tick(); tick();
        check("grant_queue_empty", exp_grant.size(), 0);
        check("write_queue_empty", exp_wr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
